// File: rtl/data_sram_resp.sv
// Responder end of the CPU data-SRAM port.
// Byte-lane writes, 1-cycle reads, zero-fill after reset.
module data_sram_resp #(
   parameter int          DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        busy,
   output logic        addr_err
);

   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic {
      CLEAR,
      READY
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [IDX_W-1:0] clr_ptr;
   logic [31:0]      mem [DEPTH];

   logic [IDX_W-1:0] idx;
   logic             in_win;
   logic [31:0]      old_word;
   logic [31:0]      merged;
   logic             fill_done;
   logic             req_ok;
   logic             unused_addr;

   assign idx         = data_sram_addr[IDX_W+1:2];
   assign in_win      = data_sram_addr[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2];
   assign old_word    = mem[idx];
   assign fill_done   = clr_ptr == IDX_W'(DEPTH - 1);
   assign req_ok      = (state_q == READY) && data_sram_en && in_win;
   assign unused_addr = ^data_sram_addr[1:0];

   // Write-first view of the addressed word: new bytes on enabled lanes.
   always_comb begin
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (data_sram_wen[i]) begin
            merged[8*i +: 8] = data_sram_wdata[8*i +: 8];
         end
      end
   end

   // Next state: fill runs until the last index is cleared.
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      case (state_q)
         CLEAR: begin
            busy = 1'b1;
            if (fill_done) begin
               state_d = READY;
            end
         end
         READY: begin
            state_d = READY;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= CLEAR;
      end else begin
         state_q <= state_d;
      end
   end

   // Fill pointer walks the array once per reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         clr_ptr <= '0;
      end else if (state_q == CLEAR) begin
         clr_ptr <= clr_ptr + 1'b1;
      end
   end

   // Single write port shared by zero-fill and lane writes.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state_q == CLEAR) begin
            mem[clr_ptr] <= '0;
         end else if (req_ok && (|data_sram_wen)) begin
            mem[idx] <= merged;
         end
      end
   end

   // Registered response and out-of-window pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_sram_rdata <= '0;
         addr_err        <= 1'b0;
      end else if ((state_q == READY) && data_sram_en) begin
         if (in_win) begin
            data_sram_rdata <= merged;
            addr_err        <= 1'b0;
         end else begin
            data_sram_rdata <= '0;
            addr_err        <= 1'b1;
         end
      end else begin
         addr_err <= 1'b0;
      end
   end

endmodule
